mul_sequencer: RTL and testbench

Multi-cycle shift-and-add multiply controller for the 4-bit-operand / 8-bit-result datapath. It accepts a start request with two operands and sequences the register file load strobes (LDA, LDB, LDO). It drives the shift-state code for the operand shifter, iterates one multiplier bit per cycle, and returns the 8-bit product with a single-cycle done pulse. It sits between the instruction decode/control logic and the register file.

---
 rtl/mul_sequencer.sv | 151 +++++++++++++++
 tb/tb_mul_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Shift-and-add multiply sequencer: drives register-file load strobes and shifter code, one multiplier bit per STEP.
// Optional macro MUL_SEQ_EARLY_EXIT_EN ends STEP as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// LOAD  | LDA/LDB strobes; clear accumulator and counter, load working regs
// STEP  | one multiplier bit per cycle, conditional add then shift
// WRITE | LDO strobe; accumulator copied into product
// DONE  | one-cycle done pulse, back to IDLE
module mul_sequencer #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     opA,
    input  logic [DATA_WIDTH-1:0]     opB,
    output logic                      busy,
    output logic                      done,
    output logic                      LDA,
    output logic                      LDB,
    output logic                      LDO,
    output logic [DATA_WIDTH-1:0]     aData,
    output logic [DATA_WIDTH-1:0]     bData,
    output logic [1:0]                shiftState,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]         acc;
    logic [PW-1:0]         mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [CW-1:0]         step_cnt;
    logic                  step_last;

    // Early exit looks at the multiplier as it will be after this step's shift.
    always_comb begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
        step_last = (step_cnt == CNT_LAST) || (mplier[DATA_WIDTH-1:1] == '0);
`else
        step_last = (step_cnt == CNT_LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        LDA        = 1'b0;
        LDB        = 1'b0;
        LDO        = 1'b0;
        shiftState = 2'b00;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                LDA       = 1'b1;
                LDB       = 1'b1;
                state_nxt = S_STEP;
            end
            S_STEP: begin
                busy       = 1'b1;
                shiftState = 2'b01;
                if (step_last) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                LDO       = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aData    <= '0;
            bData    <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            step_cnt <= '0;
            product  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        aData <= opA;
                        bData <= opB;
                    end
                end
                S_LOAD: begin
                    acc      <= '0;
                    step_cnt <= '0;
                    mplier   <= bData;
                    mcand    <= {{DATA_WIDTH{1'b0}}, aData};
                end
                S_STEP: begin
                    // Sum is bounded by (2^N-1)^2, so dropping the carry is safe.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand    <= {mcand[PW-2:0], 1'b0};
                    mplier   <= {1'b0, mplier[DATA_WIDTH-1:1]};
                    step_cnt <= step_cnt + CW'(1);
                end
                S_WRITE: begin
                    product <= acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: reset, table vectors, held start, mid-op reset, random ops.
module tb_mul_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] opA, opB;
    logic         busy, done, LDA, LDB, LDO;
    logic [W-1:0] aData, bData;
    logic [1:0]   shiftState;
    logic [2*W-1:0] product;

    int checks   = 0;
    int failures = 0;

    mul_sequencer #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .LDA(LDA), .LDB(LDB), .LDO(LDO),
        .aData(aData), .bData(bData), .shiftState(shiftState), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Number of STEP cycles the specification promises for a given multiplier.
    function automatic int steps(input logic [W-1:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        int s = 1;
        for (int i = 0; i < W; i++) if (b[i]) s = i + 1;
        return s;
`else
        return W;
`endif
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, LDA, LDB, LDO, shiftState, aData, bData, product});
    endfunction

    // Drives one operation from an IDLE cycle and checks every cycle through the return to IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble,
                          output int done_cyc, output logic [2*W-1:0] prod_at_done);
        int s = steps(b);
        int last = 4 + s;
        logic [6:0] exp_ctl;
        done_cyc = -1;
        prod_at_done = '0;
        @(negedge clk);
        opA = a; opB = b; start = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            exp_ctl = {1'(c <= 3 + s), 1'(c == 3 + s), 1'(c == 1), 1'(c == 1), 1'(c == 2 + s),
                       ((c >= 2 && c <= 1 + s) ? 2'b01 : 2'b00)};
            check($sformatf("ctl a=%0d b=%0d cyc=%0d", a, b, c),
                  32'({busy, done, LDA, LDB, LDO, shiftState}), 32'(exp_ctl));
            if (done && done_cyc < 0) begin
                done_cyc = c;
                prod_at_done = product;
            end
            if (c == 1) check("captured operands", 32'({aData, bData}), 32'({a, b}));
            if (c == 3 + s) check("model product", 32'(product), 32'(a) * 32'(b));
            start = 1'b0;
            if (scramble) begin
                opA = W'($urandom);
                opB = W'($urandom);
            end
        end
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        int             lat_full;
        int             lat_early;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int dc, lat, p, n_done, seen_done;
        logic [2*W-1:0] pd;
        logic [W-1:0] ra, rb;

        tbl[0] = '{4'd13, 4'd11, 8'h8F, 7, 7};
        tbl[1] = '{4'd15, 4'd15, 8'hE1, 7, 7};
        tbl[2] = '{4'd0,  4'd9,  8'h00, 7, 7};
        tbl[3] = '{4'd7,  4'd0,  8'h00, 7, 4};
        tbl[4] = '{4'd9,  4'd1,  8'h09, 7, 4};
        tbl[5] = '{4'd2,  4'd3,  8'h06, 7, 5};

        reset = 1'b1; start = 1'b0; opA = '0; opB = '0;
        repeat (3) @(negedge clk);
        check("outputs in reset", all_outs(), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle after reset cyc=%0d", i), all_outs(), 32'd0);
        end

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, 1'b0, dc, pd);
`ifdef MUL_SEQ_EARLY_EXIT_EN
            lat = tbl[i].lat_early;
`else
            lat = tbl[i].lat_full;
`endif
            check($sformatf("tbl[%0d] product", i), 32'(pd), 32'(tbl[i].prod));
            check($sformatf("tbl[%0d] done cycle", i), 32'(dc), 32'(lat));
        end

        // Start held high: one result per period, operands only matter in IDLE.
        p = 4 + steps(4'd5);
        n_done = 0;
        @(negedge clk);
        opA = 4'd3; opB = 4'd5; start = 1'b1;
        for (int c = 1; c <= 3 * p; c++) begin
            @(negedge clk);
            check($sformatf("held start done cyc=%0d", c), 32'(done), 32'((c % p) == p - 1));
            if (done) begin
                n_done++;
                check("held start product", 32'(product), 32'd15);
            end
            if ((c % p) == 0) begin
                opA = 4'd3; opB = 4'd5;
            end else begin
                opA = W'($urandom); opB = W'($urandom);
            end
        end
        start = 1'b0;
        check("held start done count", 32'(n_done), 32'd3);
        repeat (2) @(negedge clk);

        // Reset during the second STEP cycle of 13x11.
        @(negedge clk);
        opA = 4'd13; opB = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("second step shiftState", 32'(shiftState), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("outputs after mid-op reset", all_outs(), 32'd0);
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("no activity after reset", 32'(seen_done), 32'd0);
        run_op(4'd2, 4'd3, 1'b0, dc, pd);
        check("2x3 after reset", 32'(pd), 32'd6);

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            run_op(ra, rb, 1'b1, dc, pd);
            check($sformatf("rand %0dx%0d product", ra, rb), 32'(pd), 32'(ra) * 32'(rb));
            check($sformatf("rand %0dx%0d latency", ra, rb), 32'(dc), 32'(3 + steps(rb)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
